// File: rtl/pipeline_controller_pkg.sv
// Shared types and defaults for the 5-stage pipeline sequencer.
package pipeline_controller_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MEMWAIT = 2'd2,
    HALT    = 2'd3
  } pipe_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  localparam int unsigned DEF_MEM_TIMEOUT = 64;
  localparam int unsigned DEF_CNT_W       = 32;

  localparam int unsigned N_STAGES = 5;
  localparam logic [2:0] ST_PC    = 3'd0;
  localparam logic [2:0] ST_IFID  = 3'd1;
  localparam logic [2:0] ST_IDEX  = 3'd2;
  localparam logic [2:0] ST_EXMEM = 3'd3;
  localparam logic [2:0] ST_MEMWB = 3'd4;

  function automatic stage_ctrl_t stage_ctrl(input logic en, input logic flush);
    stage_ctrl_t c;
    c.en    = en;
    c.flush = flush;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline sequencer: per-stage enables/flushes from stall, branch and memory
// handshake, plus halt sequencing, memory timeout and performance counters.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_wb,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             halted,
  output logic             mem_error,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned       WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  pipe_state_t                          r_state, w_next;
  logic        [WAIT_W-1:0]             r_wait_cnt, w_wait_nxt;
  logic                                 r_halted, r_mem_error, r_stall_hold;
  logic                                 w_mem_wait, w_use_run, w_allow_stall, w_bubble;
  logic                                 w_err_set, w_stall_inc, w_flush_inc, w_clear;
  stage_ctrl_t [N_STAGES-1:0]           w_ctrl;
  logic                                 w_unused;

  assign w_mem_wait = mem_req & ~mem_ready;

  always_comb begin
    w_next        = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_use_run     = 1'b0;
    w_allow_stall = 1'b0;
    w_bubble      = 1'b0;
    w_err_set     = 1'b0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    w_ctrl        = '0;

    unique case (r_state)
      RUN:     begin
        w_use_run     = 1'b1;
        w_allow_stall = ~r_stall_hold;
      end
      LDSTALL: w_use_run = 1'b1;
      MEMWAIT: begin
        if (!w_mem_wait) begin
          w_use_run     = 1'b1;
          w_allow_stall = ~r_stall_hold;
        end else begin
          w_stall_inc = 1'b1;
          // The wait counter already holds the cycles spent; this is the last allowed one.
          if (r_wait_cnt >= WAIT_LAST) begin
            w_next    = HALT;
            w_err_set = 1'b1;
          end else begin
            w_wait_nxt = r_wait_cnt + WAIT_W'(1);
          end
        end
      end
      default: ;
    endcase

    if (w_use_run) begin
      if (halt_wb) begin
        w_next = HALT;
      end else if (w_mem_wait) begin
        w_next      = MEMWAIT;
        w_wait_nxt  = WAIT_W'(1);
        w_stall_inc = 1'b1;
      end else if (branch_taken) begin
        // A stall raised alongside a taken branch belongs to the wrong path.
        w_ctrl                = {N_STAGES{stage_ctrl(1'b1, 1'b0)}};
        w_ctrl[ST_IFID].flush  = 1'b1;
        w_ctrl[ST_IDEX].flush  = 1'b1;
        w_ctrl[ST_EXMEM].flush = 1'b1;
        w_flush_inc           = 1'b1;
        w_next                = RUN;
      end else if (stall_req && w_allow_stall) begin
        w_ctrl[ST_EXMEM] = stage_ctrl(1'b1, 1'b1);
        w_ctrl[ST_MEMWB] = stage_ctrl(1'b1, 1'b0);
        w_bubble         = 1'b1;
        w_stall_inc      = 1'b1;
        w_next           = LDSTALL;
      end else begin
        w_ctrl = {N_STAGES{stage_ctrl(1'b1, 1'b0)}};
        w_next = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= RUN;
      r_wait_cnt   <= '0;
      r_halted     <= 1'b0;
      r_mem_error  <= 1'b0;
      r_stall_hold <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_wait_cnt   <= w_wait_nxt;
      r_halted     <= (w_next == HALT);
      r_mem_error  <= r_mem_error | w_err_set;
      // A request still high since its bubble is the same hazard; never bubble it twice.
      r_stall_hold <= stall_req & (w_bubble | r_stall_hold);
    end
  end

  assign en_pc       = rst & w_ctrl[ST_PC].en;
  assign en_ifid     = rst & w_ctrl[ST_IFID].en;
  assign en_idex     = rst & w_ctrl[ST_IDEX].en;
  assign en_exmem    = rst & w_ctrl[ST_EXMEM].en;
  assign en_memwb    = rst & w_ctrl[ST_MEMWB].en;
  assign flush_ifid  = rst & w_ctrl[ST_IFID].flush;
  assign flush_idex  = rst & w_ctrl[ST_IDEX].flush;
  assign flush_exmem = rst & w_ctrl[ST_EXMEM].flush;
  assign halted      = r_halted;
  assign mem_error   = r_mem_error;
  assign w_unused    = ^{w_ctrl[ST_PC].flush, w_ctrl[ST_MEMWB].flush};

  assign w_clear = ~rst;

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk    (clk),
    .i_clear(w_clear),
    .i_inc  (~r_halted),
    .o_count(cycle_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .i_clear(w_clear),
    .i_inc  (w_stall_inc),
    .o_count(stall_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk    (clk),
    .i_clear(w_clear),
    .i_inc  (w_flush_inc),
    .o_count(flush_count)
  );

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: a default instance and a small one
// (MEM_TIMEOUT=4, CNT_W=4) driven by the same inputs.
module tb_pipeline_controller;

  localparam logic [7:0] CT_IDLE = 8'b11111_000;
  localparam logic [7:0] CT_FRZ  = 8'b00000_000;
  localparam logic [7:0] CT_BUB  = 8'b00011_001;
  localparam logic [7:0] CT_BR   = 8'b11111_111;

  logic clk = 1'b0;
  logic rst, stall_req, branch_taken, mem_req, mem_ready, halt_wb;

  logic        en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic        flush_ifid, flush_idex, flush_exmem, halted, mem_error;
  logic [31:0] cycle_count, stall_count, flush_count;

  logic        s_en_pc, s_en_ifid, s_en_idex, s_en_exmem, s_en_memwb;
  logic        s_flush_ifid, s_flush_idex, s_flush_exmem, s_halted, s_mem_error;
  logic [3:0]  s_cycle_count, s_stall_count, s_flush_count;

  logic [7:0] ctrl, s_ctrl;
  int n_cmp = 0;
  int n_err = 0;

  assign ctrl   = {en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, flush_exmem};
  assign s_ctrl = {s_en_pc, s_en_ifid, s_en_idex, s_en_exmem, s_en_memwb,
                   s_flush_ifid, s_flush_idex, s_flush_exmem};

  always #5 clk = ~clk;

  pipeline_controller dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_wb(halt_wb),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem), .en_memwb(en_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .halted(halted), .mem_error(mem_error),
    .cycle_count(cycle_count), .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_wb(halt_wb),
    .en_pc(s_en_pc), .en_ifid(s_en_ifid), .en_idex(s_en_idex), .en_exmem(s_en_exmem),
    .en_memwb(s_en_memwb), .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex),
    .flush_exmem(s_flush_exmem), .halted(s_halted), .mem_error(s_mem_error),
    .cycle_count(s_cycle_count), .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; stall_req = 1'b0; branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; halt_wb = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; stall_req = 1'b0; branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; halt_wb = 1'b0;

    // Reset state
    step();
    check_val("rst_ctrl", 32'(ctrl), 32'(CT_FRZ));
    check_val("rst_halted", 32'(halted), 32'd0);
    check_val("rst_mem_error", 32'(mem_error), 32'd0);
    check_val("rst_cycle", cycle_count, 32'd0);
    check_val("rst_stall", stall_count, 32'd0);
    check_val("rst_flush", flush_count, 32'd0);
    rst = 1'b1; #1;
    check_val("run_idle", 32'(ctrl), 32'(CT_IDLE));
    step();
    check_val("cycle_first", cycle_count, 32'd1);

    // Load-use: stall held three cycles gives one bubble
    do_reset();
    stall_req = 1'b1; #1;
    check_val("ldu_bubble", 32'(ctrl), 32'(CT_BUB));
    step();
    check_val("ldu_ldstall", 32'(ctrl), 32'(CT_IDLE));
    step();
    check_val("ldu_held", 32'(ctrl), 32'(CT_IDLE));
    step();
    stall_req = 1'b0; #1;
    check_val("ldu_stall_cnt", stall_count, 32'd1);
    check_val("ldu_flush_cnt", flush_count, 32'd0);

    // Branch with simultaneous stall
    do_reset();
    branch_taken = 1'b1; stall_req = 1'b1; #1;
    check_val("br_ctrl", 32'(ctrl), 32'(CT_BR));
    step();
    branch_taken = 1'b0; stall_req = 1'b0; #1;
    check_val("br_flush_cnt", flush_count, 32'd1);
    check_val("br_stall_cnt", stall_count, 32'd0);
    check_val("br_next_idle", 32'(ctrl), 32'(CT_IDLE));
    stall_req = 1'b1; #1;
    check_val("br_state_run", 32'(ctrl), 32'(CT_BUB));
    step();
    stall_req = 1'b0; #1;
    check_val("br_stall_after", stall_count, 32'd1);

    // Memory wait of 5 cycles with a branch held in EX/MEM
    do_reset();
    mem_req = 1'b1; branch_taken = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("mw_freeze%0d", i), 32'(ctrl), 32'(CT_FRZ));
      step();
    end
    mem_ready = 1'b1; #1;
    check_val("mw_release", 32'(ctrl), 32'(CT_BR));
    step();
    mem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; #1;
    check_val("mw_stall_cnt", stall_count, 32'd5);
    check_val("mw_flush_cnt", flush_count, 32'd1);
    check_val("mw_after", 32'(ctrl), 32'(CT_IDLE));
    check_val("mw_no_err", 32'(mem_error), 32'd0);

    // Timeout on the MEM_TIMEOUT=4 instance
    do_reset();
    mem_req = 1'b1;
    repeat (3) step();
    check_val("to_err_early", 32'(s_mem_error), 32'd0);
    check_val("to_halt_early", 32'(s_halted), 32'd0);
    step();
    check_val("to_err", 32'(s_mem_error), 32'd1);
    check_val("to_halted", 32'(s_halted), 32'd1);
    check_val("to_stall_cnt", 32'(s_stall_count), 32'd4);
    mem_req = 1'b0; #1;
    check_val("to_halt_ctrl", 32'(s_ctrl), 32'(CT_FRZ));
    repeat (3) step();
    check_val("to_err_sticky", 32'(s_mem_error), 32'd1);
    check_val("to_halt_sticky", 32'(s_halted), 32'd1);
    check_val("to_cycle_frozen", 32'(s_cycle_count), 32'd4);
    rst = 1'b0;
    step();
    check_val("to_rst_err", 32'(s_mem_error), 32'd0);
    check_val("to_rst_halted", 32'(s_halted), 32'd0);
    rst = 1'b1;

    // Halt pulse
    do_reset();
    step();
    halt_wb = 1'b1; #1;
    check_val("halt_ctrl", 32'(ctrl), 32'(CT_FRZ));
    check_val("halt_not_yet", 32'(halted), 32'd0);
    step();
    halt_wb = 1'b0; #1;
    check_val("halt_set", 32'(halted), 32'd1);
    check_val("halt_ctrl_after", 32'(ctrl), 32'(CT_FRZ));
    check_val("halt_cycle", cycle_count, 32'd2);
    repeat (3) step();
    check_val("halt_cycle_frozen", cycle_count, 32'd2);
    check_val("halt_sticky", 32'(halted), 32'd1);

    // Reset in the middle of a memory wait
    do_reset();
    mem_req = 1'b1;
    step();
    step();
    check_val("rmw_frozen", 32'(ctrl), 32'(CT_FRZ));
    rst = 1'b0; mem_ready = 1'b1; #1;
    check_val("rmw_rst_ctrl", 32'(ctrl), 32'(CT_FRZ));
    step();
    check_val("rmw_stall", stall_count, 32'd0);
    check_val("rmw_halted", 32'(halted), 32'd0);
    rst = 1'b1; mem_req = 1'b0; mem_ready = 1'b0; #1;
    check_val("rmw_run", 32'(ctrl), 32'(CT_IDLE));
    step();
    check_val("rmw_cycle", cycle_count, 32'd1);

    // Counter saturation on the 4-bit instance
    do_reset();
    repeat (20) step();
    check_val("sat_small", 32'(s_cycle_count), 32'd15);
    check_val("sat_big", cycle_count, 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
